traffic_light_ctrl_param: RTL and testbench

TRAFFIC_LIGHT_CTRL_PARAM -- requirements
Module: traffic_light_ctrl_param

---
 rtl/traffic_light_ctrl_param.sv | 137 +++++++++++++
 tb/tb_traffic_light_ctrl_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl_param.sv
// Two-way intersection controller with pedestrian early-termination of green
// and a flashing-yellow night mode entered from the all-red clearance phases.
module traffic_light_ctrl_param #(
   parameter int unsigned GREEN_CYC     = 15,
   parameter int unsigned YELLOW_CYC    = 3,
   parameter int unsigned ALLRED_CYC    = 3,
   parameter int unsigned MIN_GREEN_CYC = 5,
   parameter int unsigned FLASH_CYC     = 4,
   parameter int unsigned CNT_W         = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ped_req,
   input  logic       night_mode,
   output logic [2:0] LED_NS,
   output logic [2:0] LED_WE,
   output logic       ped_served,
   output logic [2:0] phase
);

   if (MIN_GREEN_CYC < 1 || MIN_GREEN_CYC > GREEN_CYC ||
       GREEN_CYC < 1 || YELLOW_CYC < 1 || ALLRED_CYC < 1 || FLASH_CYC < 1 ||
       64'(GREEN_CYC) >= (64'(1) << CNT_W) || 64'(YELLOW_CYC) >= (64'(1) << CNT_W) ||
       64'(ALLRED_CYC) >= (64'(1) << CNT_W) || 64'(FLASH_CYC) >= (64'(1) << CNT_W)) begin : g_param_chk
      $error("traffic_light_ctrl_param: illegal phase length parameters");
   end

   localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(GREEN_CYC - 1);
   localparam logic [CNT_W-1:0] MG_LAST = CNT_W'(MIN_GREEN_CYC - 1);
   localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_CYC - 1);
   localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALLRED_CYC - 1);
   localparam logic [CNT_W-1:0] F_LAST  = CNT_W'(FLASH_CYC - 1);

   typedef enum logic [2:0] {
      NS_G  = 3'd0,
      NS_Y  = 3'd1,
      AR1   = 3'd2,
      WE_G  = 3'd3,
      WE_Y  = 3'd4,
      AR2   = 3'd5,
      FLASH = 3'd6
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic             blink_q, blink_d;
   logic             served_q, served_d;
   logic             pend_eff, early;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= NS_G;
         cnt_q    <= '0;
         pend_q   <= 1'b0;
         blink_q  <= 1'b1;
         served_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         blink_q  <= blink_d;
         served_q <= served_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CNT_W'(1);
      pend_d   = pend_q | ped_req;
      blink_d  = blink_q;
      served_d = 1'b0;
      pend_eff = pend_q | ped_req;
      early    = 1'b0;
      case (state_q)
         NS_G, WE_G: begin
            // A request landing exactly on the timeout cycle counts as a normal timeout.
            early = pend_eff && (cnt_q >= MG_LAST) && (cnt_q != G_LAST);
            if (early || cnt_q == G_LAST) begin
               state_d  = (state_q == NS_G) ? NS_Y : WE_Y;
               cnt_d    = '0;
               pend_d   = 1'b0;
               served_d = early;
            end
         end
         NS_Y, WE_Y: begin
            if (cnt_q == Y_LAST) begin
               state_d = (state_q == NS_Y) ? AR1 : AR2;
               cnt_d   = '0;
            end
         end
         AR1, AR2: begin
            if (cnt_q == AR_LAST) begin
               cnt_d = '0;
               if (night_mode) begin
                  state_d = FLASH;
                  blink_d = 1'b1;
               end else begin
                  state_d = (state_q == AR1) ? WE_G : NS_G;
               end
            end
         end
         FLASH: begin
            if (!night_mode) begin
               state_d = AR2;
               cnt_d   = '0;
            end else if (cnt_q == F_LAST) begin
               cnt_d   = '0;
               blink_d = ~blink_q;
            end
         end
         default: begin
            state_d = AR2;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      LED_NS     = 3'b100;
      LED_WE     = 3'b100;
      phase      = state_q;
      ped_served = served_q;
      case (state_q)
         NS_G:    LED_NS = 3'b001;
         NS_Y:    LED_NS = 3'b010;
         WE_G:    LED_WE = 3'b001;
         WE_Y:    LED_WE = 3'b010;
         FLASH: begin
            LED_NS = blink_q ? 3'b010 : 3'b000;
            LED_WE = blink_q ? 3'b010 : 3'b000;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Directed bench for traffic_light_ctrl_param at default parameters.
module tb_traffic_light_ctrl_param;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ped_req = 1'b0;
   logic       night_mode = 1'b0;
   logic [2:0] LED_NS, LED_WE;
   logic       ped_served;
   logic [2:0] phase;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned served_cnt = 0;
   int unsigned conflict_cnt = 0;

   traffic_light_ctrl_param #(
      .GREEN_CYC(15), .YELLOW_CYC(3), .ALLRED_CYC(3),
      .MIN_GREEN_CYC(5), .FLASH_CYC(4), .CNT_W(8)
   ) dut (
      .clk(clk), .rst(rst), .ped_req(ped_req), .night_mode(night_mode),
      .LED_NS(LED_NS), .LED_WE(LED_WE), .ped_served(ped_served), .phase(phase)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "simulation time limit");
   end

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (ped_served) served_cnt++;
      if (phase != 3'd6 && LED_NS != 3'b100 && LED_WE != 3'b100) conflict_cnt++;
   endtask

   function automatic int unsigned exp_ns(input int unsigned p);
      case (p)
         0: return 1;
         1: return 2;
         default: return 4;
      endcase
   endfunction

   function automatic int unsigned exp_we(input int unsigned p);
      case (p)
         3: return 1;
         4: return 2;
         default: return 4;
      endcase
   endfunction

   // Checks state and lamps now, then steps until the state changes and checks
   // the total dwell; 'done' is the number of cycles already spent in the state.
   task automatic phase_len(input int unsigned p, input int unsigned done,
                            input int unsigned exp_len, input string tag);
      int unsigned n;
      n = done;
      chk({tag, "_phase"}, phase, p);
      chk({tag, "_ns"}, LED_NS, exp_ns(p));
      chk({tag, "_we"}, LED_WE, exp_we(p));
      while (phase == 3'(p) && n < 100) begin
         step();
         n++;
      end
      chk({tag, "_len"}, n, exp_len);
   endtask

   initial begin
      rst = 1'b0;
      step();
      step();
      chk("rst_phase", phase, 0);
      chk("rst_ns", LED_NS, 1);
      chk("rst_we", LED_WE, 4);
      chk("rst_served", ped_served, 0);
      rst = 1'b1;

      // Free-running cycle, twice
      served_cnt = 0;
      for (int k = 0; k < 2; k++) begin
         phase_len(0, 0, 15, "base_nsg");
         phase_len(1, 0, 3, "base_nsy");
         phase_len(2, 0, 3, "base_ar1");
         phase_len(3, 0, 15, "base_weg");
         phase_len(4, 0, 3, "base_wey");
         phase_len(5, 0, 3, "base_ar2");
      end
      chk("base_no_served", served_cnt, 0);

      // Pedestrian pulse at count 1 of NS_G
      served_cnt = 0;
      step();
      ped_req = 1'b1;
      step();
      ped_req = 1'b0;
      phase_len(0, 2, 5, "ped1_nsg");
      chk("ped1_served_first_y", ped_served, 1);
      step();
      chk("ped1_served_second_y", ped_served, 0);
      phase_len(1, 1, 3, "ped1_nsy");
      phase_len(2, 0, 3, "ped1_ar1");
      phase_len(3, 0, 15, "ped1_weg");
      phase_len(4, 0, 3, "ped1_wey");
      phase_len(5, 0, 3, "ped1_ar2");
      chk("ped1_pulses", served_cnt, 1);

      // Pedestrian pulse at count 10 of NS_G: green ends in that same cycle
      served_cnt = 0;
      for (int i = 0; i < 10; i++) step();
      chk("ped10_still_green", phase, 0);
      ped_req = 1'b1;
      step();
      ped_req = 1'b0;
      chk("ped10_ends_c10", phase, 1);
      chk("ped10_served", ped_served, 1);
      phase_len(1, 0, 3, "ped10_nsy");
      phase_len(2, 0, 3, "ped10_ar1");
      phase_len(3, 0, 15, "ped10_weg");
      phase_len(4, 0, 3, "ped10_wey");
      phase_len(5, 0, 3, "ped10_ar2");
      chk("ped10_pulses", served_cnt, 1);

      // Request latched during AR1 shortens the following WE green
      served_cnt = 0;
      phase_len(0, 0, 15, "par_nsg");
      phase_len(1, 0, 3, "par_nsy");
      ped_req = 1'b1;
      step();
      ped_req = 1'b0;
      phase_len(2, 1, 3, "par_ar1");
      phase_len(3, 0, 5, "par_weg");
      chk("par_served", ped_served, 1);
      phase_len(4, 0, 3, "par_wey");
      phase_len(5, 0, 3, "par_ar2");
      phase_len(0, 0, 15, "par_nsg2");
      chk("par_pulses", served_cnt, 1);
      phase_len(1, 0, 3, "par_nsy2");
      phase_len(2, 0, 3, "par_ar1b");
      phase_len(3, 0, 15, "par_weg2");
      phase_len(4, 0, 3, "par_wey2");
      phase_len(5, 0, 3, "par_ar2b");

      // Night mode raised mid NS_G, flash, then drop mid on-phase
      for (int i = 0; i < 5; i++) step();
      night_mode = 1'b1;
      phase_len(0, 5, 15, "nt_nsg");
      phase_len(1, 0, 3, "nt_nsy");
      phase_len(2, 0, 3, "nt_ar1");
      for (int i = 0; i < 16; i++) begin
         chk("nt_flash_phase", phase, 6);
         chk("nt_flash_ns", LED_NS, ((i / 4) % 2 == 0) ? 2 : 0);
         chk("nt_flash_we", LED_WE, ((i / 4) % 2 == 0) ? 2 : 0);
         step();
      end
      step();
      step();
      chk("nt_flash_hold", phase, 6);
      night_mode = 1'b0;
      step();
      phase_len(5, 0, 3, "nt_ar2");
      chk("nt_back_nsg", phase, 0);

      // Reset during WE_Y with a pending request
      phase_len(0, 0, 15, "rs_nsg");
      phase_len(1, 0, 3, "rs_nsy");
      phase_len(2, 0, 3, "rs_ar1");
      phase_len(3, 0, 15, "rs_weg");
      ped_req = 1'b1;
      step();
      ped_req = 1'b0;
      chk("rs_in_wey", phase, 4);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("rs_served", ped_served, 0);
      phase_len(0, 0, 15, "rs_nsg_full");

      chk("no_conflict", conflict_cnt, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
